// File: rtl/service_window_mc_if.sv
// Window-channel bundle: requests, per-channel lengths and status outputs.
// OVR is present only when SW_OVERRUN_EN is defined.
interface service_window_mc_if #(
   parameter int N_CH  = 4,
   parameter int CNT_W = 8
);
   logic [N_CH-1:0]       START;
   logic [N_CH-1:0]       ABORT;
   logic [N_CH*CNT_W-1:0] SWLEN;
   logic [N_CH-1:0]       SW_STAT;
   logic [N_CH-1:0]       DONE;
   logic                  ANY_OPEN;
`ifdef SW_OVERRUN_EN
   logic [N_CH-1:0]       OVR;
`endif

   modport master (
      output START, ABORT, SWLEN,
      input  SW_STAT, DONE, ANY_OPEN
`ifdef SW_OVERRUN_EN
      , input OVR
`endif
   );

   modport slave (
      input  START, ABORT, SWLEN,
      output SW_STAT, DONE, ANY_OPEN
`ifdef SW_OVERRUN_EN
      , output OVR
`endif
   );
endinterface

// File: rtl/service_window_mc.sv
// Multi-channel service window timer, one IDLE/OPEN FSM per channel.
// Optional sticky overrun flags (OVR) are built when SW_OVERRUN_EN is defined.
module service_window_mc #(
   parameter int N_CH   = 4,
   parameter int CNT_W  = 8,
   parameter int RETRIG = 0
) (
   input  logic                CLK,
   input  logic                RST,
   service_window_mc_if.slave  sw
);

   typedef enum logic {
      S_IDLE = 1'b0,
      S_OPEN = 1'b1
   } state_t;

   localparam logic [CNT_W-1:0] ZERO = '0;
   localparam logic [CNT_W-1:0] ONE  = {{(CNT_W-1){1'b0}}, 1'b1};
   localparam bit               RT   = (RETRIG != 0);

   logic [N_CH-1:0] w_stat;
   logic [N_CH-1:0] w_done;
   logic [N_CH-1:0] w_ovr_set;
   logic            r_any;

   for (genvar g = 0; g < N_CH; g++) begin : g_ch
      state_t           r_state, w_state_nx;
      logic [CNT_W-1:0] r_cnt, w_cnt_nx;
      logic             r_done, w_done_nx;
      logic [CNT_W-1:0] w_len;
      logic             w_start, w_abort;

      assign w_len   = sw.SWLEN[g*CNT_W +: CNT_W];
      assign w_start = sw.START[g];
      assign w_abort = sw.ABORT[g];

      // The counter itself is the length latch: SWLEN is only read on load.
      always_comb begin
         w_state_nx = r_state;
         w_cnt_nx   = r_cnt;
         w_done_nx  = 1'b0;
         unique case (r_state)
            S_IDLE: begin
               if (w_start && !w_abort) begin
                  if (w_len == ZERO) begin
                     w_done_nx = 1'b1;
                  end else begin
                     w_state_nx = S_OPEN;
                     w_cnt_nx   = w_len;
                  end
               end
            end
            S_OPEN: begin
               if (w_abort) begin
                  w_state_nx = S_IDLE;
                  w_cnt_nx   = ZERO;
               end else if (RT && w_start) begin
                  if (w_len == ZERO) begin
                     w_state_nx = S_IDLE;
                     w_cnt_nx   = ZERO;
                     w_done_nx  = 1'b1;
                  end else begin
                     w_cnt_nx = w_len;
                  end
               end else if (r_cnt == ONE) begin
                  w_state_nx = S_IDLE;
                  w_cnt_nx   = ZERO;
                  w_done_nx  = 1'b1;
               end else begin
                  w_cnt_nx = r_cnt - ONE;
               end
            end
         endcase
      end

      always_ff @(posedge CLK) begin
         if (RST) begin
            r_state <= S_IDLE;
            r_cnt   <= ZERO;
            r_done  <= 1'b0;
         end else begin
            r_state <= w_state_nx;
            r_cnt   <= w_cnt_nx;
            r_done  <= w_done_nx;
         end
      end

      assign w_stat[g]    = (r_state == S_IDLE);
      assign w_done[g]    = r_done;
      assign w_ovr_set[g] = (r_state == S_OPEN) && w_start && !w_abort;
   end

   always_ff @(posedge CLK) begin
      if (RST) begin
         r_any <= 1'b0;
      end else begin
         r_any <= ~&w_stat;
      end
   end

   assign sw.SW_STAT  = w_stat;
   assign sw.DONE     = w_done;
   assign sw.ANY_OPEN = r_any;

`ifdef SW_OVERRUN_EN
   logic [N_CH-1:0] r_ovr;

   always_ff @(posedge CLK) begin
      if (RST) begin
         r_ovr <= '0;
      end else begin
         r_ovr <= r_ovr | w_ovr_set;
      end
   end

   assign sw.OVR = r_ovr;
`else
   logic w_unused_ovr;
   assign w_unused_ovr = ^w_ovr_set;
`endif

endmodule

// File: doc/service_window_mc.md
SERVICE_WINDOW_MC -- requirements
Module: service_window_mc

Interface
REQ-001 SHALL have parameter N_CH, default 4: number of independent window channels (1..16).
REQ-002 SHALL have parameter CNT_W, default 8: window-length and counter width (2..16).
REQ-003 SHALL have parameter RETRIG, default 0: 1 = START during an open window restarts it; 0 = START ignored while open.
REQ-004 SHALL have port CLK  input  1: single clock; all state changes on its rising edge.
REQ-005 SHALL have port RST  input  1: reset, synchronous and active-high.
REQ-006 SHALL have port START  input  N_CH: per-channel window request; bit i is sampled every cycle.
REQ-007 SHALL have port ABORT  input  N_CH: per-channel forced close.
REQ-008 SHALL have port SWLEN  input  N_CH*CNT_W: per-channel window length; channel i uses bits [i*CNT_W +: CNT_W].
REQ-009 SHALL have port SW_STAT  output  N_CH: 1 = channel idle/closed, 0 = window open.
REQ-010 SHALL have port DONE  output  N_CH: one-cycle pulse on normal window completion.
REQ-011 SHALL have port ANY_OPEN  output  1: OR of all open channels, registered.

Function
REQ-012 Each channel SHALL be a two-state FSM (IDLE, OPEN), with its own CNT_W-bit down-counter and length latch.
REQ-013 In IDLE, START[i]=1 at edge t SHALL latch SWLEN[i] as L; if L>0, SW_STAT[i]=0 for exactly cycles t+1..t+L.
REQ-014 After the L-th open cycle, SW_STAT[i] SHALL return to 1 and DONE[i] SHALL pulse high for cycle t+L+1 only.
REQ-015 A START with L=0 SHALL not open a window: SW_STAT[i] stays 1 and DONE[i] pulses at t+1.
REQ-016 Changing SWLEN while OPEN SHALL not affect the current window, because only the latched L is used.
REQ-017 While OPEN with RETRIG=0, START[i] SHALL be ignored.
REQ-018 While OPEN with RETRIG=1, START[i] SHALL reload the counter with the current SWLEN[i]; the window continues for a further new-L cycles, with no DONE for the interrupted window.
REQ-019 A retrigger with new L=0 SHALL close the window next cycle and pulse DONE[i].
REQ-020 ABORT[i]=1 while OPEN SHALL force IDLE at the next edge (SW_STAT[i]=1) with no DONE.
REQ-021 ABORT[i] SHALL have priority over START[i] in the same cycle; ABORT in IDLE has no effect.
REQ-022 A START in the final open cycle with RETRIG=1 SHALL retrigger, with no DONE and SW_STAT held 0.
REQ-023 A START in the final open cycle with RETRIG=0 SHALL be ignored.
REQ-024 The counter SHALL never wrap; maximum window length is 2^CNT_W-1 cycles.
REQ-025 Channels SHALL be fully independent; simultaneous events on different channels do not interact.
REQ-026 ANY_OPEN SHALL equal ~&SW_STAT delayed by one cycle.

Reset
REQ-027 When RST=1 at an edge, every channel SHALL go to IDLE with counter 0, SW_STAT all 1, DONE all 0, ANY_OPEN 0.
REQ-028 Reset mid-window SHALL close the window with no DONE.
REQ-029 RST SHALL have priority over START and ABORT.

Configuration
REQ-030 With macro SW_OVERRUN_EN defined, the block SHALL add output OVR (N_CH): OVR[i] sets sticky on any START[i] accepted-or-ignored while OPEN and without ABORT[i]; it is cleared only by RST.
REQ-031 Without SW_OVERRUN_EN, port OVR and its logic SHALL be absent; all other behaviour is identical.

Verification
REQ-032 Basic window: N_CH=4, SWLEN[0]=5, START[0] pulse at cycle 10 -> SW_STAT[0]=0 cycles 11-15, DONE[0]=1 cycle 16 only, other channels stay 1.
REQ-033 Zero length: SWLEN[1]=0, START[1] -> SW_STAT[1] never 0, DONE[1] pulse next cycle.
REQ-034 Retrigger: RETRIG=1, L=4, START at 10 and 12 with SWLEN=6 -> SW_STAT=0 cycles 11-18, single DONE at 19; RETRIG=0 same stimulus -> open 11-14, DONE 15.
REQ-035 Abort/priority: START and ABORT same cycle in IDLE -> no window; ABORT at cycle 3 of an L=10 window -> SW_STAT=1 next cycle, no DONE.
REQ-036 Reset mid-operation: all channels open with L=200 (CNT_W=8), RST at cycle 50 -> all SW_STAT=1, DONE=0, ANY_OPEN=0 next cycle; with SW_OVERRUN_EN, OVR set by a prior overlapping START clears.
REQ-037 Maximum length: CNT_W=8, SWLEN=255 -> exactly 255 open cycles, no wrap, DONE at the 256th cycle.
